// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider controller: FSM encoding,
// minimum legal ratio and requester indices.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    localparam int MIN_RATIO = 2;
    localparam int NUM_REQ   = 2;
    localparam int REQ0      = 0;
    localparam int REQ1      = 1;

    function automatic logic [NUM_REQ-1:0] req_bit(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and registered divided clock; a synchronous load swaps the
// ratio and restarts the period at the start of its low phase.
module clk_div_core #(
    parameter int RATIO_W       = 32,
    parameter int DEFAULT_RATIO = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_ratio,
    input  logic [RATIO_W-1:0] new_ratio,
    output logic [RATIO_W-1:0] ratio_active,
    output logic               at_wrap,
    output logic               clk_out
);

    logic [RATIO_W-1:0] count;
    logic [RATIO_W-1:0] next_count;
    logic [RATIO_W-1:0] next_ratio;
    logic [RATIO_W-1:0] low_len;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        next_ratio = load_ratio ? new_ratio : ratio_active;
        at_wrap    = (count == ratio_active - RATIO_W'(1));
        next_count = (load_ratio || at_wrap) ? '0 : count + RATIO_W'(1);
        // ceil(N/2) written so the maximum ratio cannot overflow
        low_len    = next_ratio - (next_ratio >> 1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_active <= RATIO_W'(DEFAULT_RATIO);
            count        <= '0;
            clk_out      <= 1'b0;
        end else begin
            ratio_active <= next_ratio;
            count        <= next_count;
            clk_out      <= (next_count >= low_len);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Two-requester round-robin controller for the clock divider ratio.
// Define CLK_DIV_CTRL_IMMEDIATE_APPLY_EN to apply accepted ratios without waiting for a period boundary.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int RATIO_W       = 32,
    parameter int DEFAULT_RATIO = 10
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    input  logic [RATIO_W-1:0] req_ratio0,
    input  logic [RATIO_W-1:0] req_ratio1,
    output logic [1:0]         req_ready,
    output logic [1:0]         done,
    output logic [1:0]         err,
    output logic [RATIO_W-1:0] ratio_active,
    output logic               busy,
    output logic               clk_out
);

    state_t             state;
    logic               rr_ptr;
    logic               pending_id;
    logic [RATIO_W-1:0] pending_ratio;
    logic               at_wrap;
    logic               load_ratio;
    logic               grant_id;
    logic [1:0]         hs;
    logic               hs_id;
    logic [RATIO_W-1:0] hs_ratio;

    always_comb begin
        grant_id = (req_valid == 2'b11) ? rr_ptr : req_valid[REQ1];
        hs       = req_valid & req_ready;
        hs_id    = req_ready[REQ1];
        hs_ratio = hs_id ? req_ratio1 : req_ratio0;
`ifdef CLK_DIV_CTRL_IMMEDIATE_APPLY_EN
        load_ratio = (state == PENDING);
`else
        load_ratio = (state == PENDING) && at_wrap;
`endif
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            pending_id    <= 1'b0;
            pending_ratio <= RATIO_W'(DEFAULT_RATIO);
            req_ready     <= '0;
            done          <= '0;
            err           <= '0;
            busy          <= 1'b0;
        end else begin
            req_ready <= '0;
            done      <= '0;
            err       <= '0;
            unique case (state)
                IDLE: begin
                    // a raised ready marks the handshake cycle; no new grant until it resolves
                    if (req_ready != '0) begin
                        if (hs != '0) begin
                            if (hs_ratio < RATIO_W'(MIN_RATIO)) begin
                                err <= hs;
                            end else begin
                                pending_ratio <= hs_ratio;
                                pending_id    <= hs_id;
                                busy          <= 1'b1;
                                state         <= PENDING;
                            end
                        end
                    end else if (req_valid != '0) begin
                        req_ready <= req_bit(grant_id);
                        rr_ptr    <= ~grant_id;
                    end
                end
                PENDING: begin
                    if (load_ratio) begin
                        busy  <= 1'b0;
                        done  <= req_bit(pending_id);
                        state <= APPLY;
                    end
                end
                APPLY: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    clk_div_core #(
        .RATIO_W       (RATIO_W),
        .DEFAULT_RATIO (DEFAULT_RATIO)
    ) u_core (
        .clk          (clk_in),
        .rst_n        (reset),
        .load_ratio   (load_ratio),
        .new_ratio    (pending_ratio),
        .ratio_active (ratio_active),
        .at_wrap      (at_wrap),
        .clk_out      (clk_out)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed sequences, a vector table and
// randomized traffic checked by a transaction-level monitor.
`timescale 1ns/1ps
module tb_clk_div_ctrl;

    localparam int RATIO_W       = 32;
    localparam int DEFAULT_RATIO = 10;

    logic               clk_in = 1'b0;
    logic               reset  = 1'b1;
    logic [1:0]         req_valid = 2'b00;
    logic [RATIO_W-1:0] req_ratio0 = '0;
    logic [RATIO_W-1:0] req_ratio1 = '0;
    logic [1:0]         req_ready;
    logic [1:0]         done;
    logic [1:0]         err;
    logic [RATIO_W-1:0] ratio_active;
    logic               busy;
    logic               clk_out;

    always #5 clk_in = ~clk_in;

    clk_div_ctrl #(.RATIO_W(RATIO_W), .DEFAULT_RATIO(DEFAULT_RATIO)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ratio0   (req_ratio0),
        .req_ratio1   (req_ratio1),
        .req_ready    (req_ready),
        .done         (done),
        .err          (err),
        .ratio_active (ratio_active),
        .busy         (busy),
        .clk_out      (clk_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- transaction-level monitor ----------------
    logic               m_first;
    logic [1:0]         m_prev_valid;
    logic               m_prev_clk;
    int                 m_run_len;
    logic [RATIO_W-1:0] m_run_n;
    logic [RATIO_W-1:0] m_model_ratio;
    logic               m_ptr;
    logic               m_g;
    logic [1:0]         m_exp_err;
    logic               m_pend_v;
    logic               m_pend_id;
    logic [RATIO_W-1:0] m_pend_ratio;
    logic [RATIO_W-1:0] m_pend_old;
    int                 m_pend_age;
    logic [1:0]         m_hs;
    logic [RATIO_W-1:0] m_r;
    logic               m_trunc;
    longint             m_exp_len;
    int                 m_wait[2];

    initial begin
        forever begin
            @(negedge clk_in);
            if (reset == 1'b0) begin
                m_first       = 1'b1;
                m_model_ratio = RATIO_W'(DEFAULT_RATIO);
                m_ptr         = 1'b0;
                m_exp_err     = 2'b00;
                m_pend_v      = 1'b0;
                m_wait[0]     = 0;
                m_wait[1]     = 0;
                m_prev_clk    = 1'b0;
                m_prev_valid  = req_valid;
            end else begin
                // arbitration: decision taken on the valids seen one cycle earlier
                if (req_ready != 2'b00) begin
                    if (m_prev_valid == 2'b00) begin
                        check("spurious_grant", req_ready, 2'b00);
                    end else begin
                        if (m_prev_valid == 2'b11) m_g = m_ptr;
                        else if (m_prev_valid == 2'b01) m_g = 1'b0;
                        else m_g = 1'b1;
                        check("grant", req_ready, m_g ? 2'b10 : 2'b01);
                        m_ptr = ~m_g;
                    end
                end
                if (m_exp_err != 2'b00 || err != 2'b00) check("err_pulse", err, m_exp_err);
                m_exp_err = 2'b00;
                if (m_pend_v) begin
                    m_pend_age++;
                    if (done != 2'b00) begin
                        check("done_id", done, m_pend_id ? 2'b10 : 2'b01);
                        check("done_ratio", ratio_active, m_pend_ratio);
                        check("busy_at_done", busy, 1'b0);
`ifdef CLK_DIV_CTRL_IMMEDIATE_APPLY_EN
                        check("apply_latency", m_pend_age, 2);
`else
                        check("apply_boundary", {m_prev_clk, clk_out}, 2'b10);
`endif
                        m_model_ratio = m_pend_ratio;
                        m_pend_v      = 1'b0;
                    end else begin
                        check("busy_pending", busy, 1'b1);
                        if (longint'(m_pend_age) > longint'(m_pend_old) + 3) begin
                            check("apply_timeout", 0, 1);
                            m_pend_v = 1'b0;
                        end
                    end
                end else begin
                    if (done != 2'b00) check("spurious_done", done, 2'b00);
                    check("busy_idle", busy, 1'b0);
                end
                check("ratio_model", ratio_active, m_model_ratio);
                m_hs = req_valid & req_ready;
                if (m_hs != 2'b00) begin
                    m_r = m_hs[1] ? req_ratio1 : req_ratio0;
                    if (m_r < 2) begin
                        m_exp_err = m_hs;
                    end else begin
                        m_pend_v     = 1'b1;
                        m_pend_id    = m_hs[1];
                        m_pend_ratio = m_r;
                        m_pend_old   = m_model_ratio;
                        m_pend_age   = 0;
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (req_valid[i] && !m_hs[i]) m_wait[i]++;
                    else m_wait[i] = 0;
                    if (m_wait[i] > 400) begin
                        check("grant_timeout", 0, 1);
                        m_wait[i] = 0;
                    end
                end
                // clk_out run lengths: low ceil(N/2), high floor(N/2)
                m_trunc = 1'b0;
`ifdef CLK_DIV_CTRL_IMMEDIATE_APPLY_EN
                m_trunc = (done != 2'b00);
`endif
                if (m_first || m_trunc) begin
                    m_first   = 1'b0;
                    m_run_len = 1;
                    m_run_n   = m_model_ratio;
                end else if (clk_out != m_prev_clk) begin
                    m_exp_len = m_prev_clk ? longint'(m_run_n) / 2 : (longint'(m_run_n) + 1) / 2;
                    check(m_prev_clk ? "high_len" : "low_len", m_run_len, m_exp_len);
                    m_run_len = 1;
                    m_run_n   = m_model_ratio;
                end else begin
                    m_run_len++;
                end
                m_prev_clk   = clk_out;
                m_prev_valid = req_valid;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        step();
        reset = 1'b0;
        req_valid = 2'b00;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic request(input int id, input logic [RATIO_W-1:0] r,
                           output logic [1:0] got_err, output logic [1:0] got_done,
                           output int lat, output int busy_cyc);
        logic hs;
        hs = 1'b0;
        got_err = 2'b00;
        got_done = 2'b00;
        lat = 0;
        busy_cyc = 0;
        if (id == 0) req_ratio0 = r;
        else req_ratio1 = r;
        req_valid[id] = 1'b1;
        for (int c = 0; c < 400 && !hs; c++) begin
            @(negedge clk_in);
            hs = req_ready[id];
            step();
        end
        req_valid[id] = 1'b0;
        if (!hs) begin
            check("handshake_timeout", 0, 1);
        end else begin
            for (int c = 0; c < 1000 && got_err == 2'b00 && got_done == 2'b00; c++) begin
                @(negedge clk_in);
                lat++;
                busy_cyc += int'(busy);
                got_err  = err;
                got_done = done;
                step();
            end
            if (got_err == 2'b00 && got_done == 2'b00) check("outcome_timeout", 0, 1);
        end
    endtask

    task automatic both(input logic [RATIO_W-1:0] r0, input logic [RATIO_W-1:0] r1,
                        output logic [1:0] first_rdy, output logic [1:0] d0, output logic [1:0] d1);
        logic [1:0] hs;
        int nd;
        nd = 0;
        first_rdy = 2'b00;
        d0 = 2'b00;
        d1 = 2'b00;
        req_ratio0 = r0;
        req_ratio1 = r1;
        req_valid = 2'b11;
        for (int c = 0; c < 800 && nd < 2; c++) begin
            @(negedge clk_in);
            hs = req_valid & req_ready;
            if (req_ready != 2'b00 && first_rdy == 2'b00) first_rdy = req_ready;
            if (done != 2'b00) begin
                if (nd == 0) d0 = done;
                else d1 = done;
                nd++;
            end
            step();
            req_valid = req_valid & ~hs;
        end
        req_valid = 2'b00;
    endtask

    typedef struct {
        int                 id;
        logic [RATIO_W-1:0] ratio;
        bit                 rejected;
        logic [RATIO_W-1:0] ratio_after;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [1:0] ge, gd, fr, d0, d1, exp_bit;
        int lat, bc, cnt, dones;
        logic prev, hs;
        logic [RATIO_W-1:0] r;

        vecs[0] = '{1, 0,  1'b1, 6};
        vecs[1] = '{1, 1,  1'b1, 6};
        vecs[2] = '{0, 7,  1'b0, 7};
        vecs[3] = '{1, 7,  1'b0, 7};
        vecs[4] = '{0, 2,  1'b0, 2};
        vecs[5] = '{1, 3,  1'b0, 3};
        vecs[6] = '{0, 1,  1'b1, 3};
        vecs[7] = '{1, 12, 1'b0, 12};
        vecs[8] = '{0, 7,  1'b0, 7};

        // reset state
        #2 reset = 1'b0;
        @(negedge clk_in);
        check("rst_ratio", ratio_active, DEFAULT_RATIO);
        check("rst_clk_out", clk_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_err", err, 2'b00);
        step();
        reset = 1'b1;

        // free-running divide by 10 for 100 cycles
        cnt = 0;
        prev = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_in);
            if (clk_out && !prev) cnt++;
            prev = clk_out;
            step();
        end
        check("default_rises", cnt, 10);

        // requester 0 asks for 100, handshake lands at count 3
        do_reset();
        step();
        step();
        request(0, 100, ge, gd, lat, bc);
        check("r100_done", gd, 2'b01);
        check("r100_ratio", ratio_active, 100);
`ifdef CLK_DIV_CTRL_IMMEDIATE_APPLY_EN
        check("r100_latency", lat, 2);
        check("r100_busy_cycles", bc, 1);
`else
        check("r100_latency", lat, 7);
        check("r100_busy_cycles", bc, 6);
`endif
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_in);
            cnt += int'(clk_out);
            step();
        end
        check("r100_high_cycles", cnt, 50);

        // simultaneous requests, then pointer back at requester 0
        do_reset();
        both(50, 20, fr, d0, d1);
        check("both_first_grant", fr, 2'b01);
        check("both_first_done", d0, 2'b01);
        check("both_second_done", d1, 2'b10);
        check("both_ratio", ratio_active, 20);
        both(4, 6, fr, d0, d1);
        check("ptr_back_to_0", fr, 2'b01);
        check("ptr_ratio", ratio_active, 6);

        // vector table
        for (int v = 0; v < 9; v++) begin
            request(vecs[v].id, vecs[v].ratio, ge, gd, lat, bc);
            exp_bit = (vecs[v].id == 1) ? 2'b10 : 2'b01;
            check("vec_err", ge, vecs[v].rejected ? exp_bit : 2'b00);
            check("vec_done", gd, vecs[v].rejected ? 2'b00 : exp_bit);
            check("vec_ratio", ratio_active, vecs[v].ratio_after);
            if (vecs[v].rejected) check("vec_no_busy", bc, 0);
        end
        cnt = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk_in);
            cnt += int'(clk_out);
            step();
        end
        check("r7_high_cycles", cnt, 6);

        // maximum ratio, then reset in the middle of PENDING
        request(0, {RATIO_W{1'b1}}, ge, gd, lat, bc);
        check("max_done", gd, 2'b01);
        check("max_ratio", ratio_active, {RATIO_W{1'b1}});
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            cnt += int'(clk_out);
            step();
        end
        check("max_low_phase", cnt, 0);
        req_ratio1 = 5;
        req_valid[1] = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clk_in);
            hs = req_ready[1];
            step();
        end
        check("midpend_handshake", hs, 1'b1);
        reset = 1'b0;
        req_valid = 2'b00;
        @(negedge clk_in);
        check("midpend_ratio", ratio_active, DEFAULT_RATIO);
        check("midpend_clk_out", clk_out, 1'b0);
        check("midpend_busy", busy, 1'b0);
        check("midpend_done", done, 2'b00);
        step();
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_in);
            if (done != 2'b00) dones++;
            step();
        end
        check("midpend_no_done", dones, 0);
        check("midpend_ratio_after", ratio_active, DEFAULT_RATIO);

        // randomized traffic against the monitor
        do_reset();
        for (int c = 0; c < 2650; c++) begin
            @(negedge clk_in);
            fr = req_valid & req_ready;
            step();
            for (int i = 0; i < 2; i++) begin
                if (fr[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && c < 2500 && $urandom_range(0, 5) == 0) begin
                    r = RATIO_W'($urandom_range(0, 13));
                    if (i == 0) req_ratio0 = r;
                    else req_ratio1 = r;
                    req_valid[i] = 1'b1;
                end
            end
        end
        check("random_drained", req_valid, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Two-requester controller that owns the system clock divider and its ratio register.
- Arbitrates ratio-change requests between two requesters using round-robin.
- Validates each requested ratio.
- Applies an accepted ratio only at a slow-clock period boundary, so clk_out never produces a runt or stretched pulse.
- Sits between software/CSR-side requesters and the clock-generation path; it instantiates the divider datapath internally.

Parameters:
- RATIO_W, 32, width of ratio values and of the period counter.
- DEFAULT_RATIO, 10, ratio loaded at reset; must be >= 2.

Ports:
- clk_in  input  1  fast reference clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  2  per-requester request valid; held until ready.
- req_ratio0  input  RATIO_W  ratio requested by requester 0.
- req_ratio1  input  RATIO_W  ratio requested by requester 1.
- req_ready  output  2  per-requester accept strobe.
- done  output  2  one-cycle pulse when that requester's ratio takes effect.
- err  output  2  one-cycle pulse when that requester's ratio is rejected.
- ratio_active  output  RATIO_W  ratio currently driving clk_out.
- busy  output  1  high while a ratio is pending application.
- clk_out  output  1  divided clock, registered.

Behaviour:
- Reset values: ratio_active=DEFAULT_RATIO, count=0, clk_out=0, busy=0, req_ready=0, done=0, err=0, RR pointer=0, state=IDLE.
- Divider:
  - count increments each cycle, wrapping from ratio_active-1 to 0.
  - clk_out is registered from next-count: clk_out = (count >= ceil(N/2)).
  - Result: low ceil(N/2) cycles, then high floor(N/2) cycles, low phase first. N=10 gives 5/5; N=7 gives low 4, high 3.
- FSM states:
  - IDLE:
    - If any req_valid, grant one requester. If both are valid, the requester the RR pointer selects wins, and the pointer then flips to the other.
    - Grant asserts req_ready[i] for exactly 1 cycle; the handshake completes on valid&ready.
    - Ratio < 2: pulse err[i] the cycle after the handshake, stay in IDLE, leave ratio_active unchanged.
    - Otherwise: latch pending_ratio and pending_id, go to PENDING.
  - PENDING:
    - busy=1 and req_ready=0; the other requester waits.
    - When count == ratio_active-1, load ratio_active <= pending_ratio and count <= 0, go to APPLY.
  - APPLY: pulse done[pending_id], busy=0, return to IDLE.
- Timing:
  - Request-to-effect latency is 1 to ratio_active cycles, plus 1 cycle for the done pulse.
  - A loser that keeps valid high is granted the first IDLE cycle after APPLY.
- Boundary conditions:
  - Requested ratio equal to ratio_active: still sequenced through PENDING; done pulses, period unaffected.
  - Reset asserted mid-PENDING: pending request discarded with no done/err; ratio reverts to DEFAULT_RATIO.
  - Counter arithmetic is RATIO_W wide with no overflow; the maximum ratio is 2^RATIO_W-1.

Optional Feature:
- Macro: CLK_DIV_CTRL_IMMEDIATE_APPLY_EN.
- Defined: PENDING applies on the next cycle regardless of count; count restarts at 0 with clk_out=0 (a truncated period is allowed); done follows 1 cycle later.
- Undefined: boundary-aligned apply exactly as described above.

Decomposition:
- Shared package clk_div_pkg:
  - FSM state encoding (IDLE, PENDING, APPLY).
  - MIN_RATIO=2.
  - Requester index localparams.
- One natural sub-module, clk_div_core: counter plus registered clk_out with a synchronous load_ratio input. The controller FSM and arbiter stay in the top level.

Test Plan:
- Reset release, no requests, 100 us at 1 MHz clk_in: clk_out 10 rising edges, 5-low/5-high each period, ratio_active=10.
- Requester 0 asks 100 at count=3: req_ready0 pulses, busy until count=9 wrap, then ratio_active=100 and done0 pulses. Next period is exactly 50 low / 50 high.
- Both valid in the same cycle (ratio0=50, ratio1=20): requester 0 applied first (done0), then requester 1 (done1). ratio_active ends at 20 and the pointer ends at 0.
- Requester 1 asks 0, then 1: err1 pulses each time, ratio_active unchanged, busy never asserts.
- Ratio 7: clk_out low 4 / high 3, period 7. Reset pulsed low mid-PENDING: no done, ratio_active=10, clk_out=0.
- With CLK_DIV_CTRL_IMMEDIATE_APPLY_EN defined, request 20 at count=2: ratio_active=20 two cycles after the handshake, count restarts at 0.
